// File: rtl/kpg_pkg.sv
// Shared KPG encoding constants for the operand encoder and the prefix levels.
// Also holds the occupancy codes of the encoder's two-entry output buffer.
package kpg_pkg;

  localparam int NPAIR = 16;

  localparam logic [1:0] KPG_KILL = 2'b00;
  localparam logic [1:0] KPG_GEN  = 2'b11;
  localparam logic [1:0] KPG_PROP = 2'b01;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_FULL  = 2'd2;

endpackage

// File: rtl/kpg_enc_cell.sv
// One operand bit position: maps (a,b) onto a kill/propagate/generate pair plus the a^b bit.
module kpg_enc_cell
  import kpg_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [1:0] pair,
  output logic       prop
);

  // Propagate keeps its orientation: 01 when only b is set, 10 when only a is set.
  always_comb begin
    pair = KPG_KILL;
    if (a && b)
      pair = KPG_GEN;
    else if (a || b)
      pair = a ? ~KPG_PROP : KPG_PROP;
  end

  assign prop = a ^ b;

endmodule

// File: rtl/kpg_enc_16.sv
// KPG encoder for the final Wallace row, with a two-entry valid/ready skid buffer.
// Handshake: a beat transfers on a side only in a cycle where valid && ready are both high at the rising edge.
module kpg_enc_16
  import kpg_pkg::*;
#(
  parameter int NPAIR = kpg_pkg::NPAIR,
  parameter int OPW   = NPAIR - 1,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       in_a,
  input  logic [OPW-1:0]       in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*NPAIR-1:0]   conc,
  output logic [OPW-1:0]       prop
);

  logic [2*NPAIR-1:0] enc;
  logic [OPW-1:0]     enc_prop;

  // Carry-in occupies pair 0 as a pure kill or generate.
  assign enc[1:0] = {in_cin, in_cin};

  for (genvar i = 0; i < OPW; i++) begin : g_cell
    kpg_enc_cell u_cell (
      .a    (in_a[i]),
      .b    (in_b[i]),
      .pair (enc[2*i+3:2*i+2]),
      .prop (enc_prop[i])
    );
  end

  logic [2*NPAIR-1:0] conc_mem [DEPTH];
  logic [OPW-1:0]     prop_mem [DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               push;
  logic               pop;

  // in_ready depends on registered occupancy only, so out_ready never reaches upstream combinationally.
  assign in_ready  = (count < CNT_FULL);
  assign out_valid = (count != CNT_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= CNT_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        conc_mem[i] <= '0;
        prop_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        conc_mem[wr_ptr] <= enc;
        prop_mem[wr_ptr] <= enc_prop;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Slots keep stale data after a pop, so the outputs are gated to zero when empty.
  assign conc = out_valid ? conc_mem[rd_ptr] : '0;
  assign prop = out_valid ? prop_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_kpg_enc_16.sv
// Bench for kpg_enc_16: literal vector table, buffer corner sequences, async reset and random traffic.
module tb_kpg_enc_16;

  localparam int NP = 16;
  localparam int OW = NP - 1;
  localparam int W  = 2*NP + OW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_a;
  logic [OW-1:0] in_b;
  logic          in_cin;
  logic          out_valid;
  logic          out_ready;
  logic [2*NP-1:0] conc;
  logic [OW-1:0] prop;

  kpg_enc_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .conc      (conc),
    .prop      (prop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [OW-1:0]   a;
    logic [OW-1:0]   b;
    logic            cin;
    logic [2*NP-1:0] exp_conc;
    logic [OW-1:0]   exp_prop;
  } vec_t;

  vec_t tbl[12];

  // Reference: pair i is the 2-bit number a_bit*2 + b_bit placed at weight 4^i.
  function automatic logic [2*NP-1:0] ref_conc(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                               input logic cin);
    longint unsigned c;
    longint unsigned pv;
    c = cin ? 3 : 0;
    for (int i = 1; i < NP; i++) begin
      pv = 2 * ((a >> (i-1)) & 1) + ((b >> (i-1)) & 1);
      c  = c + (pv << (2*i));
    end
    return c[2*NP-1:0];
  endfunction

  function automatic logic [OW-1:0] ref_prop(input logic [OW-1:0] a, input logic [OW-1:0] b);
    logic [OW-1:0] p;
    for (int i = 0; i < OW; i++) p[i] = (a[i] != b[i]);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, check against the model, update the model, then pass the rising edge.
  task automatic cycle(input logic v, input logic [OW-1:0] a, input logic [OW-1:0] b,
                       input logic cin, input logic r);
    logic push;
    logic pop;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    out_ready = r;
    #1;
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("in_ready", in_ready, exp_q.size() < 2);
    chk("conc", conc, (exp_q.size() != 0) ? exp_q[0][W-1:OW] : '0);
    chk("prop", prop, (exp_q.size() != 0) ? exp_q[0][OW-1:0] : '0);
    push = v && (exp_q.size() < 2);
    pop  = (exp_q.size() != 0) && r;
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back({ref_conc(a, b, cin), ref_prop(a, b)});
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic async_reset();
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_conc", conc, '0);
    chk("rst_prop", prop, '0);
    exp_q.delete();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{15'h0001, 15'h0001, 1'b0, 32'h0000000C, 15'h0000};
    tbl[1]  = '{15'h7FFF, 15'h0000, 1'b1, 32'hAAAAAAAB, 15'h7FFF};
    tbl[2]  = '{15'h0000, 15'h0000, 1'b0, 32'h00000000, 15'h0000};
    tbl[3]  = '{15'h7FFF, 15'h7FFF, 1'b1, 32'hFFFFFFFF, 15'h0000};
    tbl[4]  = '{15'h5555, 15'h2AAA, 1'b0, 32'h99999998, 15'h7FFF};
    tbl[5]  = '{15'h0000, 15'h7FFF, 1'b0, 32'h55555554, 15'h7FFF};
    for (int i = 6; i < 12; i++) begin
      tbl[i].a        = OW'($urandom);
      tbl[i].b        = OW'($urandom);
      tbl[i].cin      = 1'($urandom_range(0, 1));
      tbl[i].exp_conc = ref_conc(tbl[i].a, tbl[i].b, tbl[i].cin);
      tbl[i].exp_prop = ref_prop(tbl[i].a, tbl[i].b);
    end

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    #7;
    chk("por_out_valid", out_valid, 1'b0);
    chk("por_in_ready", in_ready, 1'b1);
    chk("por_conc", conc, '0);
    chk("por_prop", prop, '0);
    #5;
    rst_n = 1'b1;

    // Table, back to back with out_ready=1: one entry in flight, newest beat at the head one cycle later.
    idle(1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
      #1;
      chk("tbl_conc", conc, tbl[i].exp_conc);
      chk("tbl_prop", prop, tbl[i].exp_prop);
      chk("tbl_out_valid", out_valid, 1'b1);
      chk("tbl_in_ready", in_ready, 1'b1);
    end
    idle(2);

    // Three beats against a stalled sink: third is held upstream until a slot frees.
    cycle(1'b1, 15'h0011, 15'h0102, 1'b0, 1'b0);
    cycle(1'b1, 15'h0203, 15'h1004, 1'b1, 1'b0);
    cycle(1'b1, 15'h7001, 15'h0770, 1'b0, 1'b0);
    cycle(1'b1, 15'h7001, 15'h0770, 1'b0, 1'b0);
    #1;
    chk("stall_head_conc", conc, ref_conc(15'h0011, 15'h0102, 1'b0));
    chk("stall_in_ready", in_ready, 1'b0);
    cycle(1'b1, 15'h7001, 15'h0770, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    idle(4);

    // Reset with a full buffer, then the first post-reset beat must be the first output.
    cycle(1'b1, 15'h1234, 15'h4321, 1'b1, 1'b0);
    cycle(1'b1, 15'h5A5A, 15'h2525, 1'b0, 1'b0);
    async_reset();
    idle(1);
    cycle(1'b1, 15'h6006, 15'h0660, 1'b1, 1'b1);
    #1;
    chk("post_rst_conc", conc, ref_conc(15'h6006, 15'h0660, 1'b1));
    idle(2);

    // Random traffic.
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 3) != 0), OW'($urandom), OW'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    idle(3);
    chk("drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
